// File: rtl/exec_opfetch.sv
// Operand-fetch sequencer: accepts one micro-op, fetches at most one memory operand,
// then issues the micro-op with stable selector codes until the ALU takes it.
module exec_opfetch #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iUopValid,
  output logic              oUopReady,
  input  logic [2:0]        iUopSel1,
  input  logic [2:0]        iUopSel2,
  input  logic [ADDR_W-1:0] iUopAddr,
  input  logic [TAG_W-1:0]  iUopTag,
  output logic              oMemReq,
  output logic [ADDR_W-1:0] oMemAddr,
  input  logic              iMemGnt,
  input  logic              iMemAck,
  input  logic [15:0]       iMemData,
  output logic [15:0]       oMem,
  output logic [2:0]        oSelIn1,
  output logic [2:0]        oSelIn2,
  output logic              oIssueValid,
  output logic [TAG_W-1:0]  oIssueTag,
  input  logic              iExecReady,
  input  logic              iFlush,
  output logic              oBusErr,
  output logic              oBusy
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  typedef enum logic [2:0] {StIdle, StMemReq, StMemWait, StIssue, StDrain} stateT;

  stateT             stateQ, stateD;
  logic [CntW-1:0]   cntQ, cntD, cntInc;
  logic [1:0]        sel1Q, sel2Q, selOut1Q, selOut2Q;
  logic [ADDR_W-1:0] addrQ;
  logic [TAG_W-1:0]  tagQ;
  logic [15:0]       memQ;
  logic              accept, capture, issueLoad, timedOut;

  // Only the low two select bits carry meaning.
  logic unusedSelHi;
  assign unusedSelHi = iUopSel1[2] ^ iUopSel2[2];

  assign cntInc   = (cntQ == CntMax) ? cntQ : cntQ + 1'b1;
  assign timedOut = (cntQ >= CntLast);

  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    accept      = 1'b0;
    capture     = 1'b0;
    oBusErr     = 1'b0;
    oUopReady   = 1'b0;
    oMemReq     = 1'b0;
    oIssueValid = 1'b0;
    unique case (stateQ)
      StIdle: begin
        oUopReady = ~iFlush;
        if (!iFlush && iUopValid) begin
          accept = 1'b1;
          stateD = (iUopSel1[1:0] == 2'd1 || iUopSel2[1:0] == 2'd1) ? StMemReq : StIssue;
        end
      end
      StMemReq: begin
        if (iFlush) begin
          stateD = StIdle;
        end else begin
          oMemReq = 1'b1;
          if (iMemGnt) begin
            cntD = '0;
            if (iMemAck) begin
              capture = 1'b1;
              stateD  = StIssue;
            end else begin
              stateD = StMemWait;
            end
          end
        end
      end
      StMemWait: begin
        // A flushed read is still outstanding; drain its ack so it cannot be reused.
        if (iFlush) begin
          stateD = StDrain;
          cntD   = '0;
        end else if (iMemAck) begin
          capture = 1'b1;
          stateD  = StIssue;
        end else if (timedOut) begin
          oBusErr = 1'b1;
          stateD  = StIdle;
        end else begin
          cntD = cntInc;
        end
      end
      StIssue: begin
        if (iFlush) begin
          stateD = StIdle;
        end else begin
          oIssueValid = 1'b1;
          if (iExecReady) stateD = StIdle;
        end
      end
      StDrain: begin
        if (!iFlush) begin
          if (iMemAck) begin
            stateD = StIdle;
          end else if (timedOut) begin
            oBusErr = 1'b1;
            stateD  = StIdle;
          end else begin
            cntD = cntInc;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign issueLoad = (stateD == StIssue) && (stateQ != StIssue);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateQ <= StIdle;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      sel1Q    <= '0;
      sel2Q    <= '0;
      addrQ    <= '0;
      tagQ     <= '0;
      memQ     <= '0;
      selOut1Q <= '0;
      selOut2Q <= '0;
    end else begin
      if (accept) begin
        sel1Q <= iUopSel1[1:0];
        sel2Q <= iUopSel2[1:0];
        addrQ <= iUopAddr;
        tagQ  <= iUopTag;
      end
      if (capture) memQ <= iMemData;
      // Selector codes only move when a micro-op enters issue.
      if (issueLoad) begin
        selOut1Q <= accept ? iUopSel1[1:0] : sel1Q;
        selOut2Q <= accept ? iUopSel2[1:0] : sel2Q;
      end
    end
  end

  assign oMemAddr  = addrQ;
  assign oMem      = memQ;
  assign oSelIn1   = {1'b0, selOut1Q};
  assign oSelIn2   = {1'b0, selOut2Q};
  assign oIssueTag = tagQ;
  assign oBusy     = (stateQ != StIdle);

endmodule

// File: tb/tb_exec_opfetch.sv
// Directed bench for exec_opfetch: a flag-based transaction model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_exec_opfetch;
  localparam int unsigned AW = 20;
  localparam int unsigned TW = 4;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          valid = 1'b0, gnt = 1'b0, ack = 1'b0, execReady = 1'b0, flush = 1'b0;
  logic [2:0]    sel1 = '0, sel2 = '0;
  logic [AW-1:0] addr = '0;
  logic [TW-1:0] tag = '0;
  logic [15:0]   data = '0;

  logic          oUopReady, oMemReq, oIssueValid, oBusErr, oBusy;
  logic [AW-1:0] oMemAddr;
  logic [15:0]   oMem;
  logic [2:0]    oSelIn1, oSelIn2;
  logic [TW-1:0] oIssueTag;

  int total = 0;
  int bad = 0;

  exec_opfetch #(.ADDR_W(AW), .TAG_W(TW), .TIMEOUT(TO)) dut (
    .iClk(clk), .iRstN(rstN), .iUopValid(valid), .oUopReady(oUopReady),
    .iUopSel1(sel1), .iUopSel2(sel2), .iUopAddr(addr), .iUopTag(tag),
    .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemGnt(gnt), .iMemAck(ack),
    .iMemData(data), .oMem(oMem), .oSelIn1(oSelIn1), .oSelIn2(oSelIn2),
    .oIssueValid(oIssueValid), .oIssueTag(oIssueTag), .iExecReady(execReady),
    .iFlush(flush), .oBusErr(oBusErr), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic isMem(input logic [2:0] a, input logic [2:0] b);
    return (a[1:0] == 2'd1) || (b[1:0] == 2'd1);
  endfunction

  // Model: a pending micro-op that may owe one read, plus an optional orphan read to drain.
  logic          mHave = 1'b0, mNeedRead = 1'b0, mGranted = 1'b0, mDrain = 1'b0;
  int unsigned   mWait = 0;
  logic [1:0]    mSel1 = '0, mSel2 = '0, mOut1 = '0, mOut2 = '0;
  logic [AW-1:0] mAddr = '0;
  logic [TW-1:0] mTag = '0;
  logic [15:0]   mMem = '0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mHave <= 1'b0; mNeedRead <= 1'b0; mGranted <= 1'b0; mDrain <= 1'b0; mWait <= 0;
      mSel1 <= '0; mSel2 <= '0; mOut1 <= '0; mOut2 <= '0; mAddr <= '0; mTag <= '0; mMem <= '0;
    end else if (flush) begin
      if (mHave && mGranted) begin
        mDrain <= 1'b1;
        mWait  <= 0;
      end
      mHave    <= 1'b0;
      mGranted <= 1'b0;
    end else if (mDrain) begin
      if (ack || mWait >= TO - 1) mDrain <= 1'b0;
      else mWait <= mWait + 1;
    end else if (!mHave) begin
      if (valid) begin
        mHave     <= 1'b1;
        mSel1     <= sel1[1:0];
        mSel2     <= sel2[1:0];
        mAddr     <= addr;
        mTag      <= tag;
        mNeedRead <= isMem(sel1, sel2);
        mGranted  <= 1'b0;
        if (!isMem(sel1, sel2)) begin
          mOut1 <= sel1[1:0];
          mOut2 <= sel2[1:0];
        end
      end
    end else if (mNeedRead && !mGranted) begin
      if (gnt && ack) begin
        mMem <= data; mNeedRead <= 1'b0; mOut1 <= mSel1; mOut2 <= mSel2;
      end else if (gnt) begin
        mGranted <= 1'b1;
        mWait    <= 0;
      end
    end else if (mGranted) begin
      if (ack) begin
        mMem <= data; mNeedRead <= 1'b0; mGranted <= 1'b0; mOut1 <= mSel1; mOut2 <= mSel2;
      end else if (mWait >= TO - 1) begin
        mHave    <= 1'b0;
        mGranted <= 1'b0;
      end else begin
        mWait <= mWait + 1;
      end
    end else if (execReady) begin
      mHave <= 1'b0;
    end
  end

  logic eReady, eMemReq, eIssue, eBusErr, eBusy;
  assign eReady  = !mHave && !mDrain && !flush;
  assign eMemReq = mHave && mNeedRead && !mGranted && !flush;
  assign eIssue  = mHave && !mNeedRead && !flush;
  assign eBusErr = !flush && !ack && (mDrain || (mHave && mGranted)) && (mWait >= TO - 1);
  assign eBusy   = mHave || mDrain;

  always @(negedge clk) begin
    chk("uopReady", oUopReady, eReady);
    chk("memReq", oMemReq, eMemReq);
    chk("issueValid", oIssueValid, eIssue);
    chk("busErr", oBusErr, eBusErr);
    chk("busy", oBusy, eBusy);
    chk("selIn1", oSelIn1, {1'b0, mOut1});
    chk("selIn2", oSelIn2, {1'b0, mOut2});
    chk("mem", oMem, mMem);
    if (eMemReq) chk("memAddr", oMemAddr, mAddr);
    if (eIssue) chk("issueTag", oIssueTag, mTag);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", oUopReady, 1); chk("rst_busy", oBusy, 0);
    chk("rst_mem", oMem, 0); chk("rst_issue", oIssueValid, 0);
    @(posedge clk); #1 rstN = 1'b1;

    // Register-only micro-op issues the cycle after accept.
    valid = 1; sel1 = 0; sel2 = 2; tag = 3; execReady = 1;
    @(negedge clk); chk("t1_accept_noissue", oIssueValid, 0);
    cyc(); valid = 0;
    @(negedge clk);
    chk("t1_issue", oIssueValid, 1); chk("t1_sel1", oSelIn1, 0);
    chk("t1_sel2", oSelIn2, 2); chk("t1_tag", oIssueTag, 3); chk("t1_noreq", oMemReq, 0);
    cyc();

    // Memory operand with grant delayed two cycles.
    execReady = 0; valid = 1; sel1 = 1; sel2 = 0; addr = 20'h12345; tag = 5;
    cyc(); valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("t2_req", oMemReq, 1); chk("t2_addr", oMemAddr, 32'h12345);
      cyc();
    end
    gnt = 1;
    @(negedge clk); chk("t2_addr_gnt", oMemAddr, 32'h12345);
    cyc(); gnt = 0; ack = 1; data = 16'hBEEF;
    @(negedge clk); chk("t2_wait_noreq", oMemReq, 0); chk("t2_wait_noissue", oIssueValid, 0);
    cyc(); ack = 0;
    @(negedge clk);
    chk("t2_issue", oIssueValid, 1); chk("t2_mem", oMem, 16'hBEEF); chk("t2_sel1", oSelIn1, 1);
    execReady = 1;
    cyc();

    // Both operands from memory, grant and ack together.
    valid = 1; sel1 = 1; sel2 = 1; addr = 20'h00ABC; tag = 7;
    cyc(); valid = 0; gnt = 1; ack = 1; data = 16'h1234;
    @(negedge clk); chk("t3_req", oMemReq, 1);
    cyc(); gnt = 0; ack = 0;
    @(negedge clk);
    chk("t3_issue", oIssueValid, 1); chk("t3_sel1", oSelIn1, 1); chk("t3_sel2", oSelIn2, 1);
    chk("t3_mem", oMem, 16'h1234); chk("t3_noreq", oMemReq, 0);
    cyc();

    // Stalled issue; the next micro-op is held valid throughout.
    execReady = 0; valid = 1; sel1 = 2; sel2 = 3; tag = 9;
    cyc(); sel1 = 0; sel2 = 0; tag = 4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_issue", oIssueValid, 1); chk("t4_tag", oIssueTag, 9);
      chk("t4_ready", oUopReady, 0); chk("t4_sel2", oSelIn2, 3);
      cyc();
    end
    execReady = 1;
    @(negedge clk); chk("t4_issue_last", oIssueValid, 1);
    cyc();
    @(negedge clk); chk("t4_idle_ready", oUopReady, 1); chk("t4_idle_noissue", oIssueValid, 0);
    cyc(); valid = 0;
    @(negedge clk);
    chk("t4_new_issue", oIssueValid, 1); chk("t4_new_tag", oIssueTag, 4);
    chk("t4_new_sel1", oSelIn1, 0);
    cyc();

    // Flush while waiting for data; the late ack is drained.
    valid = 1; sel1 = 0; sel2 = 1; addr = 20'h0F00F; tag = 2;
    cyc(); valid = 0; gnt = 1;
    cyc(); gnt = 0; flush = 1;
    @(negedge clk);
    chk("t5_flush_issue", oIssueValid, 0); chk("t5_flush_req", oMemReq, 0);
    chk("t5_flush_ready", oUopReady, 0);
    cyc(); flush = 0;
    cyc();
    cyc(); ack = 1; data = 16'h5555;
    @(negedge clk); chk("t5_drain_noerr", oBusErr, 0); chk("t5_drain_busy", oBusy, 1);
    cyc(); ack = 0;
    @(negedge clk);
    chk("t5_mem_kept", oMem, 16'h1234); chk("t5_idle", oBusy, 0);
    chk("t5_ready", oUopReady, 1); chk("t5_noissue", oIssueValid, 0);
    valid = 1; sel1 = 1; sel2 = 2; addr = 20'h00042; tag = 6;
    cyc(); valid = 0; gnt = 1;
    cyc(); gnt = 0; ack = 1; data = 16'hCAFE;
    cyc(); ack = 0;
    @(negedge clk);
    chk("t5_next_issue", oIssueValid, 1); chk("t5_next_mem", oMem, 16'hCAFE);
    chk("t5_next_tag", oIssueTag, 6); chk("t5_next_sel2", oSelIn2, 2);
    cyc();

    // Bus timeout: error pulse four cycles after the grant.
    execReady = 0; valid = 1; sel1 = 1; sel2 = 0; addr = 20'h54321; tag = 1;
    cyc(); valid = 0; gnt = 1;
    cyc(); gnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t6_noerr", oBusErr, 0);
      cyc();
    end
    @(negedge clk); chk("t6_err", oBusErr, 1);
    cyc();
    @(negedge clk);
    chk("t6_err_once", oBusErr, 0); chk("t6_idle", oBusy, 0); chk("t6_ready", oUopReady, 1);
    ack = 1; data = 16'hDEAD;
    cyc(); ack = 0;
    @(negedge clk); chk("t6_stray_mem", oMem, 16'hCAFE); chk("t6_stray_idle", oBusy, 0);
    cyc();

    // Flush beats a concurrent valid in idle.
    flush = 1; valid = 1; sel1 = 0; sel2 = 0; tag = 11;
    @(negedge clk); chk("t7_flush_ready", oUopReady, 0);
    cyc(); flush = 0; valid = 0;
    @(negedge clk); chk("t7_not_accepted", oBusy, 0); chk("t7_no_issue", oIssueValid, 0);
    cyc();

    // Stray ack without grant, then asynchronous reset in the request state.
    valid = 1; sel1 = 0; sel2 = 1; addr = 20'h11111; tag = 8;
    cyc(); valid = 0; ack = 1; data = 16'h9999;
    @(negedge clk); chk("t7_req", oMemReq, 1);
    cyc(); ack = 0;
    @(negedge clk); chk("t7_stray_mem", oMem, 16'hCAFE); chk("t7_still_req", oMemReq, 1);
    #2 rstN = 0;
    #1;
    chk("t7_async_req", oMemReq, 0); chk("t7_async_ready", oUopReady, 1);
    chk("t7_async_busy", oBusy, 0); chk("t7_async_mem", oMem, 0);
    cyc(); rstN = 1;

    // Stray ack during issue is ignored.
    execReady = 0; valid = 1; sel1 = 3; sel2 = 0; tag = 15;
    cyc(); valid = 0; ack = 1; data = 16'h7777;
    @(negedge clk); chk("t8_issue", oIssueValid, 1); chk("t8_sel1", oSelIn1, 3);
    cyc(); ack = 0;
    @(negedge clk);
    chk("t8_stray_mem", oMem, 0); chk("t8_still_issue", oIssueValid, 1);
    chk("t8_tag", oIssueTag, 15);
    execReady = 1;
    cyc(); execReady = 0;
    @(negedge clk); chk("t8_idle", oBusy, 0);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_opfetch.md
Name: exec_opfetch

Overview:
- Operand-fetch sequencer for the execute stage.
- Accepts one decoded micro-op at a time and drives the operand-selector select codes.
- When either operand is sourced from memory, performs a single memory read and holds the returned word on the selector's memory-operand input.
- Issues the micro-op to the ALU once both operands are stable, with flush and bus-timeout handling.

Parameters:
ADDR_W, 20, memory operand address width (8086 physical address)
TAG_W, 4, micro-op tag width, passed through to issue
TIMEOUT, 255, max cycles waiting for iMemAck before bus error (1..2^16-1)

Ports:
iClk  in  1  clock
iRstN  in  1  reset, asynchronous, active-low
iUopValid  in  1  decoded micro-op valid
oUopReady  out  1  block can accept micro-op
iUopSel1  in  3  operand-1 source: [1:0] 0=RF 1=MEM 2=IMM 3=const 2; bit2 ignored
iUopSel2  in  3  operand-2 source, same encoding
iUopAddr  in  ADDR_W  memory operand address
iUopTag  in  TAG_W  micro-op tag
oMemReq  out  1  memory read request
oMemAddr  out  ADDR_W  read address
iMemGnt  in  1  request accepted by memory arbiter
iMemAck  in  1  read data valid
iMemData  in  16  read data
oMem  out  16  held memory operand, to selector memory input
oSelIn1  out  3  selector code, operand 1
oSelIn2  out  3  selector code, operand 2
oIssueValid  out  1  operands valid, micro-op issued to ALU
oIssueTag  out  TAG_W  tag of issued micro-op
iExecReady  in  1  ALU accepts issue
iFlush  in  1  synchronous pipeline flush
oBusErr  out  1  one-cycle pulse on memory timeout
oBusy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; timeout counter 0; all outputs 0, except oUopReady=1.
- Reset is asynchronous and applies mid-operation; any in-flight read is abandoned.
- States: IDLE, MEMREQ, MEMWAIT, ISSUE, DRAIN.
- IDLE:
  - oUopReady=1.
  - On iUopValid, latch sel1/sel2 (bit2 forced 0), addr and tag.
  - If sel1[1:0]==1 or sel2[1:0]==1 -> MEMREQ; else -> ISSUE.
- MEMREQ:
  - oMemReq=1 and oMemAddr=latched addr, held stable until iMemGnt.
  - On iMemGnt -> MEMWAIT and clear the counter.
  - If iMemGnt and iMemAck arrive in the same cycle, capture data and go directly to ISSUE.
- MEMWAIT:
  - On iMemAck, oMem<=iMemData -> ISSUE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ack, pulse oBusErr for 1 cycle, drop the micro-op and go to IDLE.
- One memory read per micro-op, even when both operands are MEM; both selects then see the same oMem word.
- ISSUE:
  - oIssueValid=1; oSelIn1, oSelIn2, oIssueTag and oMem held stable until iExecReady.
  - On iExecReady -> IDLE.
- oSelIn1/oSelIn2 hold their last values outside ISSUE. This gives the selector stable codes; consumers must qualify them with oIssueValid.
- oMem changes only on a captured ack.
- Latency:
  - Non-memory micro-op: accept in cycle N, oIssueValid in N+1.
  - Memory micro-op with gnt in N+1 and ack in N+2: oIssueValid in N+3.
- No accept while state != IDLE. Peak throughput is one micro-op per 2 cycles.
- iFlush (highest priority after reset), from any state:
  - MEMWAIT -> DRAIN, so the outstanding ack is absorbed and not reused.
  - All other states -> IDLE.
  - oIssueValid, oMemReq and oUopReady are 0 in the flush response cycle.
  - Flush in IDLE concurrent with iUopValid: the micro-op is not accepted.
- DRAIN:
  - Wait for iMemAck (data discarded, oMem unchanged) -> IDLE.
  - The timeout applies here too: on expiry, oBusErr pulse -> IDLE.
  - iFlush in DRAIN stays in DRAIN.
- A stray iMemAck in IDLE, MEMREQ (without gnt) or ISSUE is ignored.
- Counter width is clog2(TIMEOUT+1) and it saturates.

Test Plan:
- Reset, then sel1=0, sel2=2, tag=3 -> oIssueValid=1 exactly 1 cycle after accept, oSelIn1=0, oSelIn2=2, oIssueTag=3, oMemReq never asserted.
- sel1=1, sel2=0, addr=0x12345; gnt delayed 2 cycles, ack with 0xBEEF 1 cycle later -> oMemAddr=0x12345 stable during request, oMem=0xBEEF, then issue; exactly one gnt consumed.
- sel1=1, sel2=1 -> single memory request; oSelIn1=oSelIn2=1; oMem=ack data.
- iExecReady held 0 for 5 cycles in ISSUE -> all issue outputs stable, oUopReady=0; a held-valid new micro-op is accepted only the cycle after ready.
- iFlush in MEMWAIT, then ack 3 cycles later with 0x5555 -> DRAIN absorbs it, oMem unchanged, no issue, IDLE after ack; next micro-op proceeds normally.
- TIMEOUT=4, gnt with no ack -> oBusErr single pulse 4 cycles after gnt, state IDLE; a later stray ack is ignored. Also assert iRstN low in MEMREQ -> outputs reset immediately, without waiting for a clock edge.
